ycr_arb_rr_n: RTL and testbench

- Parametrised round-robin arbiter granting one of NREQ core-side requesters access to a shared memory/bus port.
- Per-transaction handshake: req_ack marks address-phase acceptance; lack marks data-phase completion.
- Adds registered one-hot and encoded grant outputs, explicit grant-valid, non-power-of-2 wrap, and an optional lack watchdog.
- Sits between core request muxes and the downstream bridge in the YIFive interconnect.

---
 rtl/ycr_arb_pkg.sv | 7 +
 rtl/ycr_arb_rr_pick.sv | 26 ++
 rtl/ycr_arb_rr_n.sv | 106 ++++++++++
 tb/tb_ycr_arb_rr_n.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ycr_arb_pkg.sv
// ycr_arb_pkg: arbiter state encoding and modulo-N increment helper
package ycr_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_REQ_ACK, WAIT_LACK} arb_state_t;
  function automatic int mod_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/ycr_arb_rr_pick.sv
// ycr_arb_rr_pick: first active request at or after ptr, wrapping modulo NREQ
module ycr_arb_rr_pick
  import ycr_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  winner
);
  logic [IDW-1:0] idx;
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = IDW'(mod_inc(int'(idx), NREQ));
    end
  end
endmodule

// File: rtl/ycr_arb_rr_n.sv
// ycr_arb_rr_n: registered round-robin arbiter with req_ack/lack handshake; YCR_ARB_LOCK_EN adds the lock port
module ycr_arb_rr_n
  import ycr_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = $clog2(NREQ),
  parameter int LACK_TMO = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  input  logic            req_ack,
  input  logic            lack,
`ifdef YCR_ARB_LOCK_EN
  input  logic            lock,
`endif
  output logic            gnt_vld,
  output logic [IDW-1:0]  gnt_id,
  output logic [NREQ-1:0] gnt_oh,
  output logic            busy,
  output logic            tmo_err
);
  arb_state_t     state, state_n;
  logic [IDW-1:0] ptr, ptr_n, id_n, winner;
  logic           vld_n, found, locked, locked_n, lk, expire;
`ifdef YCR_ARB_LOCK_EN
  assign lk = lock;
`else
  assign lk = 1'b0;
`endif
  ycr_arb_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .found  (found),
    .winner (winner)
  );
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    id_n     = gnt_id;
    vld_n    = gnt_vld;
    locked_n = locked;
    case (state)
      IDLE: if (found) begin
        state_n = WAIT_REQ_ACK;
        id_n    = winner;
        vld_n   = 1'b1;
      end
      WAIT_REQ_ACK: if (req_ack) begin
        state_n  = WAIT_LACK;
        ptr_n    = lk ? ptr : IDW'(mod_inc(int'(gnt_id), NREQ));
        locked_n = lk;
      end else if (!req[gnt_id]) begin
        state_n = IDLE;
        vld_n   = 1'b0;
      end
      WAIT_LACK: if (lack && locked && req[gnt_id]) begin
        state_n  = WAIT_REQ_ACK;
        locked_n = 1'b0;
      end else if (lack || expire) begin
        state_n  = IDLE;
        vld_n    = 1'b0;
        locked_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
        vld_n   = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
      gnt_oh  <= '0;
      locked  <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt_id  <= id_n;
      gnt_vld <= vld_n;
      gnt_oh  <= vld_n ? (NREQ'(1) << id_n) : '0;
      locked  <= locked_n;
    end
  end
  assign busy = (state != IDLE);
  if (LACK_TMO > 0) begin : g_wd
    localparam int TW = $clog2(LACK_TMO + 1);
    logic [TW-1:0] cnt;
    assign expire = (state == WAIT_LACK) && (cnt == TW'(LACK_TMO - 1));
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt     <= '0;
        tmo_err <= 1'b0;
      end else begin
        cnt     <= (state == WAIT_LACK) ? cnt + TW'(1) : '0;
        tmo_err <= expire && !lack;
      end
    end
  end else begin : g_nowd
    assign expire  = 1'b0;
    assign tmo_err = 1'b0;
  end
endmodule

// File: tb/tb_ycr_arb_rr_n.sv
// tb_ycr_arb_rr_n: table-driven and scoreboard checks of the round-robin arbiter
module tb_ycr_arb_rr_n;
  logic clk = 1'b0, rstn = 1'b0, req_ack = 1'b0, lack = 1'b0, lock = 1'b0;
  logic [3:0] req4 = '0, oh4;
  logic [4:0] req5 = '0, oh5;
  logic [1:0] id4;
  logic [2:0] id5;
  logic v4, b4, t4, v5, b5, t5;
  int errors = 0, checks = 0, n;
  int q[$];
  typedef struct {logic [3:0] req; int exp;} vec_t;
  vec_t tbl[10];
  int seq5[4];
  always #5 clk = ~clk;
  ycr_arb_rr_n #(.NREQ(4), .LACK_TMO(8)) u4 (
    .clk(clk), .rstn(rstn), .req(req4), .req_ack(req_ack), .lack(lack),
`ifdef YCR_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt_vld(v4), .gnt_id(id4), .gnt_oh(oh4), .busy(b4), .tmo_err(t4)
  );
  ycr_arb_rr_n #(.NREQ(5), .LACK_TMO(0)) u5 (
    .clk(clk), .rstn(rstn), .req(req5), .req_ack(req_ack), .lack(lack),
`ifdef YCR_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt_vld(v5), .gnt_id(id5), .gnt_oh(oh5), .busy(b5), .tmo_err(t5)
  );
  function automatic int gv(input int sel);  return sel ? int'(v5)  : int'(v4);  endfunction
  function automatic int gid(input int sel); return sel ? int'(id5) : int'(id4); endfunction
  function automatic int goh(input int sel); return sel ? int'(oh5) : int'(oh4); endfunction
  function automatic int bsy(input int sel); return sel ? int'(b5)  : int'(b4);  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic grant(input int sel, output int waited);
    int e;
    waited = 0;
    while (gv(sel) == 0 && waited < 8) begin
      tick();
      waited++;
    end
    chk("grant_vld", gv(sel), 1);
    if (q.size() == 0) chk("scoreboard_underflow", 1, 0);
    else begin
      e = q.pop_front();
      chk("gnt_id", gid(sel), e);
      chk("gnt_oh", goh(sel), 1 << e);
    end
  endtask
  task automatic xact(input int sel, input int exp);
    int w;
    q.push_back(exp);
    grant(sel, w);
    chk("grant_latency", w, 1);
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    tick();
    lack = 1'b1;
    tick();
    lack = 1'b0;
    chk("release_vld", gv(sel), 0);
    chk("release_oh", goh(sel), 0);
    chk("id_keep", gid(sel), exp);
    chk("release_busy", bsy(sel), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{4'b1111, 0};
    tbl[1] = '{4'b1111, 1};
    tbl[2] = '{4'b1111, 2};
    tbl[3] = '{4'b1111, 3};
    tbl[4] = '{4'b1111, 0};
    tbl[5] = '{4'b1000, 3};
    tbl[6] = '{4'b0110, 1};
    tbl[7] = '{4'b0011, 0};
    tbl[8] = '{4'b1100, 2};
    tbl[9] = '{4'b0101, 0};
    seq5 = '{0, 4, 0, 4};
    tick();
    tick();
    chk("rst_vld", int'(v4), 0);
    chk("rst_id", int'(id4), 0);
    chk("rst_oh", int'(oh4), 0);
    chk("rst_busy", int'(b4), 0);
    chk("rst_tmo", int'(t4), 0);
    chk("rst_vld5", int'(v5), 0);
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      req4 = tbl[i].req;
      xact(0, tbl[i].exp);
    end
    req4 = '0;
    req5 = 5'b10001;
    for (int i = 0; i < 4; i++) xact(1, seq5[i]);
    req5 = '0;
    req4 = 4'b0010;
    xact(0, 1);
    req4 = 4'b0100;
    q.push_back(2);
    grant(0, n);
    chk("abort_grant_latency", n, 1);
    req4 = '0;
    tick();
    chk("abort_vld", int'(v4), 0);
    chk("abort_busy", int'(b4), 0);
    req4 = 4'b1111;
    q.push_back(2);
    grant(0, n);
    chk("regrant_latency", n, 1);
    req_ack = 1'b1;
    req4 = '0;
    tick();
    req_ack = 1'b0;
    chk("ack_wins_vld", int'(v4), 1);
    chk("ack_wins_busy", int'(b4), 1);
    tick();
    chk("ack_wins_held", int'(v4), 1);
    lack = 1'b1;
    tick();
    lack = 1'b0;
    chk("ack_wins_release", int'(v4), 0);
    req4 = 4'b1001;
    xact(0, 3);
    req4 = 4'b0100;
    q.push_back(2);
    grant(0, n);
    chk("wd_grant_latency", n, 1);
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("wd_hold", int'(v4 && !t4), 1);
    end
    tick();
    chk("wd_release", int'(v4), 0);
    chk("wd_tmo_pulse", int'(t4), 1);
    tick();
    chk("wd_tmo_one_cycle", int'(t4), 0);
    q.push_back(2);
    grant(0, n);
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    repeat (7) tick();
    lack = 1'b1;
    tick();
    lack = 1'b0;
    req4 = '0;
    chk("wd_lack_release", int'(v4), 0);
    chk("wd_lack_no_tmo", int'(t4), 0);
    tick();
    chk("wd_no_late_tmo", int'(t4), 0);
    req4 = 4'b0010;
    q.push_back(1);
    grant(0, n);
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    chk("async_rst_vld", int'(v4), 0);
    chk("async_rst_id", int'(id4), 0);
    chk("async_rst_oh", int'(oh4), 0);
    chk("async_rst_busy", int'(b4), 0);
    chk("async_rst_tmo", int'(t4), 0);
    req4 = '0;
    tick();
    tick();
    rstn = 1'b1;
    req4 = 4'b1111;
    xact(0, 0);
`ifdef YCR_ARB_LOCK_EN
    req4 = 4'b0011;
    q.push_back(1);
    grant(0, n);
    chk("lock_grant_latency", n, 1);
    lock = 1'b1;
    req_ack = 1'b1;
    tick();
    lock = 1'b0;
    req_ack = 1'b0;
    chk("lock_wait_lack", int'(v4), 1);
    tick();
    lack = 1'b1;
    tick();
    lack = 1'b0;
    chk("lock_regrant_vld", int'(v4), 1);
    chk("lock_regrant_id", int'(id4), 1);
    chk("lock_regrant_busy", int'(b4), 1);
    tick();
    chk("lock_regrant_held", int'(v4), 1);
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    tick();
    lack = 1'b1;
    tick();
    lack = 1'b0;
    chk("unlock_release", int'(v4), 0);
    xact(0, 0);
`endif
    req4 = '0;
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
